// File: rtl/alu_issue_if.sv
// Issue-side, ALU-side and write-back signals of the ALU operand issue stage.
// The slave modport is the issue block's view; the master modport is its environment's view.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [3:0]  sel_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Op1;
  logic [31:0] Op2;
  logic [3:0]  Sel;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  modport slave (
    input  in_valid, rs, rt, sel_in, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, Op1, Op2, Sel
  );

  modport master (
    output in_valid, rs, rt, sel_in, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, Op1, Op2, Sel
  );
endinterface

// File: rtl/alu_issue.sv
// ALU operand issue stage: 32x32 register bank with write-back bypass feeding a
// two-entry (main + skid) output buffer toward the ALU.
//
// state | meaning
// EMPTY | no entry buffered, outputs invalid
// ONE   | main entry valid
// TWO   | main and skid entries valid, upstream stalled
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  sel;
  } entry_t;

  state_t      state_q, state_d;
  entry_t      main_q, main_d;
  entry_t      skid_q, skid_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic   in_ready;
  logic   out_valid;
  logic   accept;
  logic   pop;
  logic   wb_hit;
  entry_t cap;

  // Ready comes from state alone so out_ready never reaches in_ready combinationally.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;
  assign wb_hit    = bus.wb_en && (bus.wb_addr != 5'd0);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.Op1       = main_q.op1;
  assign bus.Op2       = main_q.op2;
  assign bus.Sel       = main_q.sel;

  // Same-cycle write-back wins over the stale bank entry.
  always_comb begin
    cap.sel = bus.sel_in;
    if (bus.rs == 5'd0)
      cap.op1 = 32'd0;
    else if (wb_hit && (bus.wb_addr == bus.rs))
      cap.op1 = bus.wb_data;
    else
      cap.op1 = regs_q[bus.rs];
    if (bus.rt == 5'd0)
      cap.op2 = 32'd0;
    else if (wb_hit && (bus.wb_addr == bus.rt))
      cap.op2 = bus.wb_data;
    else
      cap.op2 = regs_q[bus.rt];
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_hit)
      regs_d[bus.wb_addr] = bus.wb_data;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = cap;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = cap;
        end else if (accept) begin
          skid_d  = cap;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      for (int i = 0; i < 32; i++)
        regs_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: queue/array reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_issue;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_issue_if bus ();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  sel;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] mregs [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
    return mregs[idx];
  endfunction

  // Reference model: the buffer is just a FIFO of capacity 2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else begin
      exp_t e;
      bit   acc;
      bit   pp;
      acc   = bus.in_valid && (mq.size() < 2);
      pp    = (mq.size() > 0) && bus.out_ready;
      e.op1 = model_read(bus.rs);
      e.op2 = model_read(bus.rt);
      e.sel = bus.sel_in;
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(e);
      if (bus.wb_en && bus.wb_addr != 5'd0) mregs[bus.wb_addr] = bus.wb_data;
    end
  end

  always @(negedge clk) begin
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() < 2});
    if (!rst_n) begin
      check("rst_op1", bus.Op1, 32'd0);
      check("rst_op2", bus.Op2, 32'd0);
      check("rst_sel", {28'd0, bus.Sel}, 32'd0);
    end else if (mq.size() > 0) begin
      check("op1", bus.Op1, mq[0].op1);
      check("op2", bus.Op2, mq[0].op2);
      check("sel", {28'd0, bus.Sel}, {28'd0, mq[0].sel});
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    cyc();
    bus.wb_en = 1'b0;
  endtask

  task automatic issue(input logic [4:0] s, input logic [4:0] t, input logic [3:0] op);
    bus.in_valid = 1'b1; bus.rs = s; bus.rt = t; bus.sel_in = op;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.rs = '0; bus.rt = '0; bus.sel_in = '0;
    bus.out_ready = 1'b0; bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    #1;
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_op1", bus.Op1, 32'd0);
    cyc();
    rst_n = 1'b1;

    // Basic issue after write-back
    wb(5'd5, 32'h0000_00AA);
    wb(5'd6, 32'h0000_0055);
    bus.out_ready = 1'b1;
    issue(5'd5, 5'd6, 4'b0010);
    cyc();
    bus.in_valid = 1'b0;
    check("basic_valid", {31'd0, bus.out_valid}, 32'd1);
    check("basic_op1", bus.Op1, 32'h0000_00AA);
    check("basic_op2", bus.Op2, 32'h0000_0055);
    check("basic_sel", {28'd0, bus.Sel}, 32'h2);
    cyc();

    // Same-cycle bypass
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h1234_5678;
    issue(5'd7, 5'd0, 4'h1);
    cyc();
    bus.wb_en = 1'b0; bus.in_valid = 1'b0;
    check("bypass_op1", bus.Op1, 32'h1234_5678);
    check("bypass_op2", bus.Op2, 32'd0);
    cyc();

    // Write to entry 0 ignored
    wb(5'd0, 32'hFFFF_FFFF);
    issue(5'd0, 5'd0, 4'h3);
    cyc();
    bus.in_valid = 1'b0;
    check("r0_op1", bus.Op1, 32'd0);
    cyc();

    // Back-pressure fills skid, then drains in order
    bus.out_ready = 1'b0;
    issue(5'd5, 5'd6, 4'h1);
    cyc();
    issue(5'd7, 5'd5, 4'h3);
    cyc();
    bus.in_valid = 1'b0;
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("full_hold_a", bus.Op1, 32'h0000_00AA);
    wb(5'd5, 32'hDEAD_BEEF);
    check("hold_a_sel", {28'd0, bus.Sel}, 32'h1);
    bus.out_ready = 1'b1;
    cyc();
    check("pop_a_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("b_op1", bus.Op1, 32'h1234_5678);
    check("b_op2_snapshot", bus.Op2, 32'h0000_00AA);
    cyc();
    check("drained", {31'd0, bus.out_valid}, 32'd0);

    // Accept and pop together for three cycles
    issue(5'd6, 5'd7, 4'h4);
    cyc();
    for (int i = 0; i < 3; i++) begin
      issue(5'd5, 5'd6, 4'(5 + i));
      cyc();
      check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("stream_sel", {28'd0, bus.Sel}, 32'(5 + i));
    end
    bus.in_valid = 1'b0;
    cyc();

    // Async reset while TWO
    bus.out_ready = 1'b0;
    issue(5'd5, 5'd6, 4'h9);
    cyc();
    cyc();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", {31'd0, bus.out_valid}, 32'd0);
    check("areset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("areset_op1", bus.Op1, 32'd0);
    check("areset_op2", bus.Op2, 32'd0);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hCAFE_F00D;
    cyc();
    rst_n = 1'b1;
    bus.wb_en = 1'b0;
    bus.out_ready = 1'b1;
    issue(5'd5, 5'd6, 4'h2);
    cyc();
    bus.in_valid = 1'b0;
    check("post_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    check("post_reset_op1", bus.Op1, 32'd0);
    check("post_reset_op2", bus.Op2, 32'd0);
    cyc();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.rs        = 5'($urandom_range(0, 7));
      bus.rt        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.sel_in    = 4'($urandom);
      bus.wb_en     = ($urandom_range(0, 1) != 0);
      bus.wb_addr   = 5'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      if (n == 1500) begin
        #2;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  upstream issue request valid.
REQ-004 in_ready  output  1  block can accept an issue request this cycle.
REQ-005 rs  input  5  register index for Op1.
REQ-006 rt  input  5  register index for Op2.
REQ-007 sel_in  input  4  ALU operation code, passed through unchanged.
REQ-008 out_valid  output  1  Op1/Op2/Sel valid toward ALU.
REQ-009 out_ready  input  1  downstream consumes the current output this cycle.
REQ-010 Op1  output  32  first ALU operand.
REQ-011 Op2  output  32  second ALU operand.
REQ-012 Sel  output  4  ALU operation select.
REQ-013 wb_en  input  1  write-back enable.
REQ-014 wb_addr  input  5  write-back register index.
REQ-015 wb_data  input  32  write-back data (ALU Out).

Function
REQ-016 Register bank SHALL be 32 x 32-bit; entry 0 SHALL always read 0; writes to entry 0 SHALL be ignored.
REQ-017 Write SHALL occur on the rising edge when wb_en=1 and wb_addr!=0.
REQ-018 Issue accepted SHALL be defined as in_valid=1 and in_ready=1 at a rising edge; pop SHALL be defined as out_valid=1 and out_ready=1 at a rising edge.
REQ-019 On accept, operands SHALL be snapshotted: Op1 = reg[rs], Op2 = reg[rt], Sel = sel_in.
REQ-020 Bypass: if wb_en=1, wb_addr!=0 and wb_addr equals rs (resp. rt) in the accept cycle, captured operand SHALL be wb_data, not the stale entry.
REQ-021 Captured entries SHALL NOT be modified by later write-backs.
REQ-022 Latency: request accepted at edge N SHALL appear on outputs with out_valid=1 after edge N when the buffer held no older entry.
REQ-023 Output buffer SHALL be 2 entries (main + skid), FSM states EMPTY, ONE, TWO; outputs SHALL always drive the main entry.
REQ-024 EMPTY: accept -> ONE (load main); otherwise stay.
REQ-025 ONE: accept without pop -> TWO (load skid); pop without accept -> EMPTY; accept and pop -> ONE (main reloaded with new entry); neither -> stay.
REQ-026 TWO: pop -> ONE (skid moves to main); no accept possible.
REQ-027 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, derived from state only (no combinational path from out_ready).
REQ-028 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-029 Entries SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-030 While out_valid=1 and out_ready=0, Op1/Op2/Sel SHALL remain stable.
REQ-031 In EMPTY, Op1/Op2/Sel SHALL hold last values (don't-care for checking).

Reset
REQ-032 rst_n=0 SHALL immediately, without clock, force state EMPTY, out_valid=0, in_ready=1, Op1=0, Op2=0, Sel=0, all 32 registers 0.
REQ-033 Reset asserted mid-operation SHALL discard both buffered entries and any write-back of that cycle.
REQ-034 After rst_n rises, first accept SHALL be possible at the first rising edge.

Verification
REQ-035 Write reg5=0x0000_00AA, reg6=0x0000_0055; issue rs=5, rt=6, sel_in=0010, out_ready=1 -> next cycle out_valid=1, Op1=0xAA, Op2=0x55, Sel=0010.
REQ-036 Same cycle: wb_en=1, wb_addr=7, wb_data=0x1234_5678 and accept rs=7, rt=0 -> Op1=0x1234_5678, Op2=0.
REQ-037 wb_en=1, wb_addr=0, wb_data=0xFFFF_FFFF, then issue rs=0 -> Op1=0.
REQ-038 out_ready=0, issue A then B -> in_ready=0 after second accept, outputs hold A; raise out_ready -> A then B popped in order, in_ready returns 1 after first pop.
REQ-039 State ONE, accept C and pop simultaneously for three consecutive cycles -> out_valid stays 1, one entry per cycle, in_ready stays 1.
REQ-040 State TWO, pull rst_n=0 between edges -> out_valid=0, in_ready=1, Op1=Op2=0 immediately; reads of reg5 after reset return 0.
